if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction fetch stage; drives the IF/ID pipeline register that feeds id_stage.
//   Holds the fetch PC and issues word reads to instruction memory over a valid/ready request
//   channel with a variable-latency response channel.
//   Buffers returned words in a small fetch FIFO; stalls on id_hazard_flag; redirects on a taken branch.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch PC loaded on reset
//   FBUF_DEPTH  2              fetch FIFO entries ({pc,inst}); power of 2, >=2
// PORTS
//   clk             in   1   system clock; all state on rising edge
//   rst             in   1   reset, asynchronous, active-high
//   id_hazard_flag  in   1   ID stall request: hold IF/ID register
//   ex_take_branch  in   1   taken branch/jump redirect (from EX)
//   ex_target_pc    in   32  redirect target; bits [1:0] forced to 0
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts request
//   imem_addr       out  32  fetch address (word aligned)
//   imem_rsp_valid  in   1   response data valid (1 cycle pulse)
//   imem_rsp_data   in   32  returned instruction word
//   if_id_IR        out  32  instruction to ID
//   if_id_PC        out  32  PC of if_id_IR
//   if_id_valid_inst out 1   if_id_IR is a real instruction
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, FSM=REQ, FIFO count=0, imem_req_valid=0 while rst high,
//     if_id_IR=32'h0000_0013 (NOP), if_id_PC=0, if_id_valid_inst=0.
//   Fetch FSM, max one outstanding request:
//     REQ:    imem_req_valid = (count<FBUF_DEPTH) & ~ex_take_branch; imem_addr=fetch_pc;
//             valid&ready -> latch req_pc=fetch_pc, go WAIT. rsp_valid in REQ ignored.
//     WAIT:   imem_req_valid=0; rsp_valid -> push {req_pc,data}, fetch_pc+=4, go REQ.
//     SQUASH: imem_req_valid=0; rsp_valid -> drop data, go REQ (fetch_pc unchanged).
//   Earliest response is 1 cycle after acceptance; peak rate 1 word / 2 cycles.
//   FIFO never overflows: issue needs count<FBUF_DEPTH, only one push per request.
//   IF/ID update each edge, priority order:
//     1 ex_take_branch: FIFO flushed (count=0), IF/ID <= NOP, valid=0; fetch_pc<=target;
//       WAIT->SQUASH, SQUASH stays, REQ stays. Overrides stall and same-cycle push.
//     2 id_hazard_flag: IF/ID holds; no pop; push still allowed.
//     3 count>0: pop head into IF/ID, valid=1.
//     4 else: IF/ID <= NOP, PC held, valid=0 (bubble).
//   Push and pop in same cycle: count unchanged; pop reads pre-push head.
//   fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
//   Reset mid-WAIT: state discarded; memory is reset by same rst, no late response expected.
// CONFIGURATION
//   FETCH_BYPASS_EN defined: in WAIT, rsp_valid with count==0, no stall, no redirect ->
//     word loaded straight into IF/ID this edge (no FIFO push), valid=1; saves 1 cycle.
//   Not defined: every response goes through the FIFO (rsp edge N -> IF/ID edge N+1).
// TESTING
//   Reset, RESET_PC=0x100, ready=1, rsp 1 cycle later -> imem_addr 0x100,0x104,0x108; IF/ID PC in order, valid=1.
//   Stall: hazard high 4 cycles with FIFO filling -> IF/ID held; at most FBUF_DEPTH words; req_valid low when full.
//   Redirect in WAIT to 0x2000 -> stale rsp dropped; next req addr 0x2000; IF/ID NOP, valid=0.
//   Redirect + hazard same cycle -> IF/ID becomes NOP, FIFO empty, stall ignored.
//   imem_req_ready low 5 cycles -> req_valid stays high, addr stable, IF/ID bubbles (valid=0).
//   Async rst pulse mid-WAIT between edges -> outputs reset immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage feeding the IF/ID pipeline register
//
// Purpose:
//   Holds the fetch PC and issues word reads to instruction memory over a
//   valid/ready request channel with a variable-latency response. At most one
//   request is outstanding at a time. Returned words are buffered in a small
//   fetch FIFO and then popped into the IF/ID register. The stage holds IF/ID
//   on an ID hazard, and flushes and redirects on a taken branch from EX.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   When defined, a response that arrives while the FIFO is empty, with no
//   stall and no redirect, is written straight into IF/ID on the same edge.
//   When undefined, every response passes through the FIFO.
//
// Parameters:
//   RESET_PC    fetch PC loaded on reset
//   FBUF_DEPTH  fetch FIFO entries ({pc,inst}); power of 2, >= 2
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   id_hazard_flag    ID stall request: hold IF/ID, no pop
//   ex_take_branch    taken branch/jump redirect from EX
//   ex_target_pc      redirect target (bits [1:0] ignored)
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts request
//   imem_addr         word-aligned fetch address
//   imem_rsp_valid    response data valid (single-cycle pulse)
//   imem_rsp_data     returned instruction word
//   if_id_IR          instruction to ID
//   if_id_PC          PC of if_id_IR
//   if_id_valid_inst  if_id_IR is a real instruction

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_hazard_flag,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  localparam int          PTR_W = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        fifo_pc_q   [FBUF_DEPTH];
  logic [31:0]        fifo_pc_d   [FBUF_DEPTH];
  logic [31:0]        fifo_inst_q [FBUF_DEPTH];
  logic [31:0]        fifo_inst_d [FBUF_DEPTH];
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        pc_q, pc_d;
  logic               valid_q, valid_d;

  logic               fifo_empty;
  logic               bypass;
  logic               push;
  logic               pop;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    valid_d     = valid_q;

    // Gated by rst so no request is visible while reset is held.
    imem_req_valid = ~rst & (state_q == S_REQ) &
                     (count_q < CNT_W'(FBUF_DEPTH)) & ~ex_take_branch;
    imem_addr      = fetch_pc_q;

    fifo_empty = (count_q == '0);
    bypass     = BYPASS_EN & (state_q == S_WAIT) & imem_rsp_valid &
                 fifo_empty & ~id_hazard_flag;
    push       = (state_q == S_WAIT) & imem_rsp_valid & ~bypass;
    pop        = ~id_hazard_flag & ~fifo_empty;

    if (ex_take_branch) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      ir_d       = NOP;
      valid_d    = 1'b0;
      fetch_pc_d = ex_target_pc & 32'hFFFF_FFFC;
      // A response landing on the redirect edge retires the outstanding
      // request (data dropped); otherwise wait in SQUASH for the stale word.
      if (state_q != S_REQ) begin
        state_d = imem_rsp_valid ? S_REQ : S_SQUASH;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc_d = fetch_pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_REQ;
          end
        end
        S_SQUASH: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase

      if (bypass) begin
        ir_d    = imem_rsp_data;
        pc_d    = req_pc_q;
        valid_d = 1'b1;
      end else if (id_hazard_flag) begin
        ir_d    = ir_q;
      end else if (pop) begin
        // Head is read before this edge's push lands.
        ir_d    = fifo_inst_q[rd_ptr_q];
        pc_d    = fifo_pc_q[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        ir_d    = NOP;
        valid_d = 1'b0;
      end

      if (push) begin
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        fifo_inst_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FBUF_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
      ir_q       <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign if_id_IR         = ir_q;
  assign if_id_PC         = pc_q;
  assign if_id_valid_inst = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage

module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_hazard_flag;
  logic        ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  if_stage #(.RESET_PC(RST_PC), .FBUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_hazard_flag  (id_hazard_flag),
    .ex_take_branch  (ex_take_branch),
    .ex_target_pc    (ex_target_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_id_IR        (if_id_IR),
    .if_id_PC        (if_id_PC),
    .if_id_valid_inst(if_id_valid_inst)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  // Reference model: fetch queue of {pc,inst}, one outstanding request flag,
  // a "discard next response" flag after a redirect, and the IF/ID contents.
  logic [63:0] m_fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_discard;
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  bit          m_valid;

  // Memory side: one pending response after a random latency.
  bit          mem_pend;
  int          mem_lat;
  logic [31:0] mem_addr;
  int          min_lat = 1;
  int          max_lat = 1;
  logic [31:0] fired_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_fetch_pc = RST_PC;
    m_req_pc   = RST_PC;
    m_out      = 0;
    m_discard  = 0;
    m_ir       = NOP;
    m_pc       = 32'h0;
    m_valid    = 0;
    mem_pend   = 0;
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input bit hz, input bit br, input logic [31:0] tgt, input bit rdy);
    bit          rsp;
    bit          exp_rv;
    bit          fire;
    bit          have_entry;
    bit          byp;
    logic [31:0] rdata;
    logic [63:0] entry;
    logic [63:0] head;
    rsp   = 0;
    rdata = $urandom;
    if (mem_pend) begin
      if (mem_lat <= 1) begin
        rsp      = 1;
        rdata    = mem_word(mem_addr);
        mem_pend = 0;
      end else begin
        mem_lat--;
      end
    end
    id_hazard_flag = hz;
    ex_take_branch = br;
    ex_target_pc   = tgt;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    exp_rv = !m_out && (m_fifo.size() < DEPTH) && !br;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_addr, m_fetch_pc);
    fire = exp_rv && rdy;
    if (fire) begin
      mem_pend = 1;
      mem_lat  = $urandom_range(max_lat, min_lat);
      mem_addr = m_fetch_pc;
      fired_q.push_back(m_fetch_pc);
    end

    if (br) begin
      m_fifo.delete();
      m_ir       = NOP;
      m_valid    = 0;
      m_fetch_pc = tgt & 32'hFFFF_FFFC;
      if (m_out) begin
        if (rsp) begin
          m_out     = 0;
          m_discard = 0;
        end else begin
          m_discard = 1;
        end
      end
    end else begin
      have_entry = 0;
      byp        = 0;
      entry      = '0;
      if (m_out && rsp) begin
        m_out = 0;
        if (m_discard) begin
          m_discard = 0;
        end else begin
          have_entry = 1;
          entry      = {m_req_pc, rdata};
          m_fetch_pc = m_fetch_pc + 32'd4;
`ifdef FETCH_BYPASS_EN
          byp = (m_fifo.size() == 0) && !hz;
`endif
        end
      end
      if (byp) begin
        m_pc    = entry[63:32];
        m_ir    = entry[31:0];
        m_valid = 1;
      end else if (!hz) begin
        if (m_fifo.size() > 0) begin
          head    = m_fifo.pop_front();
          m_pc    = head[63:32];
          m_ir    = head[31:0];
          m_valid = 1;
        end else begin
          m_ir    = NOP;
          m_valid = 0;
        end
      end
      if (have_entry && !byp) m_fifo.push_back(entry);
      if (fire) begin
        m_out     = 1;
        m_discard = 0;
        m_req_pc  = mem_addr;
      end
    end

    @(posedge clk);
    #1;
    chk("if_id_valid", if_id_valid_inst, m_valid);
    chk("if_id_IR", if_id_IR, m_ir);
    if (m_valid) chk("if_id_PC", if_id_PC, m_pc);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst            = 1'b1;
    id_hazard_flag = 1'b0;
    ex_take_branch = 1'b0;
    ex_target_pc   = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_IR", if_id_IR, NOP);
    chk("rst_PC", if_id_PC, 32'h0);
    chk("rst_valid", if_id_valid_inst, 1'b0);
    rst = 1'b0;

    // Straight-line fetch, single-cycle memory.
    min_lat = 1; max_lat = 1;
    fired_q.delete();
    repeat (12) step(0, 0, 32'h0, 1);
    chk("seq_count", fired_q.size() >= 3, 1'b1);
    chk("seq_addr0", fired_q[0], 32'h100);
    chk("seq_addr1", fired_q[1], 32'h104);
    chk("seq_addr2", fired_q[2], 32'h108);

    // Stall with FIFO filling, then drain.
    repeat (8) step(1, 0, 32'h0, 1);
    repeat (6) step(0, 0, 32'h0, 1);

    // Redirect while a request is outstanding.
    min_lat = 3; max_lat = 3;
    guard = 0;
    while (!(m_out && mem_pend) && guard < 20) begin
      step(0, 0, 32'h0, 1);
      guard++;
    end
    chk("wait_reached", m_out && mem_pend, 1'b1);
    fired_q.delete();
    step(0, 1, 32'h2000, 1);
    chk("redir_IR", if_id_IR, NOP);
    chk("redir_valid", if_id_valid_inst, 1'b0);
    repeat (10) step(0, 0, 32'h0, 1);
    chk("redir_addr", fired_q[0], 32'h2000);

    // Redirect and hazard on the same edge.
    min_lat = 1; max_lat = 1;
    repeat (6) step(1, 0, 32'h0, 1);
    step(1, 1, 32'h3000, 1);
    chk("redir_hz_IR", if_id_IR, NOP);
    chk("redir_hz_valid", if_id_valid_inst, 1'b0);
    repeat (4) step(0, 0, 32'h0, 1);

    // Memory not ready for five cycles.
    repeat (3) step(0, 0, 32'h0, 1);
    repeat (5) step(0, 0, 32'h0, 0);
    repeat (4) step(0, 0, 32'h0, 1);

    // Redirect near the top of the address space to exercise PC wrap.
    step(0, 1, 32'hFFFF_FFF9, 1);
    repeat (10) step(0, 0, 32'h0, 1);

    // Randomized traffic.
    min_lat = 1; max_lat = 4;
    repeat (400) step($urandom_range(99) < 30, $urandom_range(99) < 5,
                      $urandom, $urandom_range(99) < 70);

    // Asynchronous reset pulse while waiting for a response.
    min_lat = 4; max_lat = 4;
    guard = 0;
    while (!(m_out && mem_pend) && guard < 20) begin
      step(0, 0, 32'h0, 1);
      guard++;
    end
    chk("wait_reached2", m_out && mem_pend, 1'b1);
    id_hazard_flag = 1'b0;
    ex_take_branch = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", imem_req_valid, 1'b0);
    chk("arst_IR", if_id_IR, NOP);
    chk("arst_PC", if_id_PC, 32'h0);
    chk("arst_valid", if_id_valid_inst, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    min_lat = 1; max_lat = 1;
    fired_q.delete();
    repeat (10) step(0, 0, 32'h0, 1);
    chk("arst_restart", fired_q[0], 32'h100);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
